// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, constants and sizing helpers for the chunked CLA adder
//   state_e    : IDLE / RUN / DONE
//   num_chunks : number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width  : chunk counter width, never narrower than 1 bit
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// rtl/cla_seq_adder_if.sv - operand/result handshake bundle for cla_seq_adder
//   master : issuing stage (drives in_valid, a, b, cin, op_sub, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, cout, overflow)
//   CLA_SEQ_FLAGS_EN adds zero/negative result flags driven by the slave
interface cla_seq_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
`ifdef CLA_SEQ_FLAGS_EN
  logic             zero;
  logic             negative;

  modport master (output in_valid, a, b, cin, op_sub, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow, zero, negative);
  modport slave  (input  in_valid, a, b, cin, op_sub, out_ready,
                  output in_ready, out_valid, sum, cout, overflow, zero, negative);
`else
  modport master (output in_valid, a, b, cin, op_sub, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow);
  modport slave  (input  in_valid, a, b, cin, op_sub, out_ready,
                  output in_ready, out_valid, sum, cout, overflow);
`endif
endinterface

// File: rtl/cla_chunk.sv
// rtl/cla_chunk.sv - combinational CHUNK-bit carry-lookahead slice
//   a, b     : CHUNK-bit operand slices
//   cin      : carry into bit 0
//   sum      : CHUNK-bit slice sum
//   cout     : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (signed overflow detection)
module cla_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries inside each 4-bit group are fully expanded; groups chain through
  // their group generate/propagate so only NG group carries are serial.
  always_comb begin
    logic gc;
    logic grp_g;
    logic grp_p;
    c  = '0;
    gc = cin;
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc;
      c[4*j+1] = g[4*j] | (p[4*j] & gc);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc);
      grp_g    = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p    = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      gc       = grp_g | (grp_p & gc);
    end
    c[CHUNK] = gc;
  end

  assign sum      = p ^ c[CHUNK-1:0];
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle adder/subtractor, CHUNK bits per cycle
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of cla_seq_adder_if (operand accept, result hold)
//   CLA_SEQ_FLAGS_EN : also registers zero/negative result flags
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst_n,
  cla_seq_adder_if.slave  bus
);
  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;
  logic             last_chunk;

`ifdef CLA_SEQ_FLAGS_EN
  logic             nz_acc_q;
  logic             zero_q;
  logic             neg_q;
`endif

  // Operands shift right each RUN cycle so the active chunk is always at bit 0.
  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .cin      (carry_q),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  assign last_chunk = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
      nz_acc_q    <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
            b_q        <= (bus.op_sub == ALU_OP_SUB) ? ~bus.b : bus.b;
            carry_q    <= (bus.op_sub == ALU_OP_SUB) ? 1'b1 : bus.cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef CLA_SEQ_FLAGS_EN
            nz_acc_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[int'(cnt_q)*CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_cout;
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          cnt_q   <= cnt_q + 1'b1;
`ifdef CLA_SEQ_FLAGS_EN
          nz_acc_q <= nz_acc_q | (|slice_sum);
`endif
          if (last_chunk) begin
            cout_q      <= slice_cout;
            ovf_q       <= slice_c_msb ^ slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef CLA_SEQ_FLAGS_EN
            zero_q      <= ~(nz_acc_q | (|slice_sum));
            neg_q       <= slice_sum[CHUNK-1];
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
`ifdef CLA_SEQ_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - self-checking bench for cla_seq_adder (32/4 directed, 64/8 random)
module tb_cla_seq_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        sel = 1'b0;          // 0: 32/4 instance, 1: 64/8 instance
  logic        in_valid_d = 1'b0;
  logic        out_ready_d = 1'b0;
  logic [63:0] a_d = '0;
  logic [63:0] b_d = '0;
  logic        cin_d = 1'b0;
  logic        sub_d = 1'b0;

  cla_seq_adder_if #(.WIDTH(32)) if32 ();
  cla_seq_adder_if #(.WIDTH(64)) if64 ();

  assign if32.in_valid  = in_valid_d & ~sel;
  assign if32.out_ready = out_ready_d & ~sel;
  assign if32.a         = a_d[31:0];
  assign if32.b         = b_d[31:0];
  assign if32.cin       = cin_d;
  assign if32.op_sub    = sub_d;
  assign if64.in_valid  = in_valid_d & sel;
  assign if64.out_ready = out_ready_d & sel;
  assign if64.a         = a_d;
  assign if64.b         = b_d;
  assign if64.cin       = cin_d;
  assign if64.op_sub    = sub_d;

  cla_seq_adder #(.WIDTH(32), .CHUNK(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  cla_seq_adder #(.WIDTH(64), .CHUNK(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  logic [63:0] obs_sum;
  logic        obs_cout, obs_ovf, obs_in_ready, obs_out_valid;
  assign obs_sum       = sel ? if64.sum : {32'b0, if32.sum};
  assign obs_cout      = sel ? if64.cout : if32.cout;
  assign obs_ovf       = sel ? if64.overflow : if32.overflow;
  assign obs_in_ready  = sel ? if64.in_ready : if32.in_ready;
  assign obs_out_valid = sel ? if64.out_valid : if32.out_valid;
`ifdef CLA_SEQ_FLAGS_EN
  logic obs_zero, obs_neg;
  assign obs_zero = sel ? if64.zero : if32.zero;
  assign obs_neg  = sel ? if64.negative : if32.negative;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic for sum/cout, signed range test for overflow.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, ea, eb;
    logic [64:0] full;
    logic signed [65:0] sa, sb, r, maxv, minv;
    mask = (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
    if (sub) begin
      full = {1'b0, a & mask} - {1'b0, b & mask};
      co   = ((a & mask) >= (b & mask));
    end else begin
      full = {1'b0, a & mask} + {1'b0, b & mask} + 65'(cin);
      co   = full[w];
    end
    s    = full[63:0] & mask;
    ea   = a[w-1] ? (a | ~mask) : (a & mask);
    eb   = b[w-1] ? (b | ~mask) : (b & mask);
    sa   = $signed({{2{ea[63]}}, ea});
    sb   = $signed({{2{eb[63]}}, eb});
    r    = sub ? (sa - sb) : (sa + sb + $signed({65'b0, cin}));
    maxv = (66'sd1 <<< (w - 1)) - 66'sd1;
    minv = -maxv - 66'sd1;
    ov   = (r > maxv) || (r < minv);
  endtask

  // One full transaction; churn_at > 0 scrambles the inputs after that RUN cycle.
  task automatic do_op(input logic s64, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input int hold, input int churn_at);
    int w, lat, guard;
    logic [63:0] es;
    logic eco, eov;
    w   = s64 ? 64 : 32;
    sel = s64;
    guard = 0;
    while (!obs_in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      check("in_ready_timeout", 64'(obs_in_ready), 64'd1);
      return;
    end
    a_d = a; b_d = b; cin_d = cin; sub_d = sub; in_valid_d = 1'b1;
    model(w, a, b, cin, sub, es, eco, eov);
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    lat = 0;
    while (!obs_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (lat == churn_at) begin
        a_d = {$urandom, $urandom}; b_d = ~b_d; cin_d = ~cin_d; sub_d = ~sub_d;
      end
    end
    check("latency", 64'(lat), 64'd8);
    check("sum", obs_sum, es);
    check("cout", 64'(obs_cout), 64'(eco));
    check("overflow", 64'(obs_ovf), 64'(eov));
`ifdef CLA_SEQ_FLAGS_EN
    check("zero", 64'(obs_zero), 64'(es == 64'd0));
    check("negative", 64'(obs_neg), 64'(es[w-1]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(obs_out_valid), 64'd1);
      check("hold_sum", obs_sum, es);
      check("hold_flags", {62'b0, obs_cout, obs_ovf}, {62'b0, eco, eov});
      check("hold_in_ready", 64'(obs_in_ready), 64'd0);
    end
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    out_ready_d = 1'b0;
    check("valid_clear", 64'(obs_out_valid), 64'd0);
    check("ready_back", 64'(obs_in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    logic [63:0] ra, rb;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      check("rst_sum", obs_sum, 64'd0);
      check("rst_flags", {61'b0, obs_cout, obs_ovf, obs_out_valid}, 64'd0);
      check("rst_in_ready", 64'(obs_in_ready), 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 0, 0);
    do_op(1'b0, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 0, 0);
    do_op(1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 0, 0);
    do_op(1'b0, 64'd5, 64'd7, 1'b0, 1'b1, 0, 0);
    do_op(1'b0, 64'h80000000, 64'h1, 1'b0, 1'b1, 0, 0);
    do_op(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0);
    do_op(1'b0, 64'h12345678, 64'h0FEDCBA9, 1'b1, 1'b0, 5, 0);
    do_op(1'b0, 64'hA5A5A5A5, 64'h5A5A5A5A, 1'b0, 1'b1, 0, 0);
    do_op(1'b0, 64'hDEADBEEF, 64'h01234567, 1'b1, 1'b0, 0, 3);

    // Reset in the middle of RUN discards the operation.
    sel = 1'b0;
    a_d = 64'h1111; b_d = 64'h2222; cin_d = 1'b0; sub_d = 1'b0; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sum", obs_sum, 64'd0);
    check("midrst_flags", {61'b0, obs_cout, obs_ovf, obs_out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 64'(obs_in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (obs_out_valid) seen++;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);

    do_op(1'b1, 64'h5, 64'h5, 1'b0, 1'b1, 0, 0);
    do_op(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 1, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = '1;
        2: rb = 64'h8000000000000000;
        default: ;
      endcase
      do_op(1'b1, ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
